// File: rtl/dmem_if.sv
// Load/store handshake bundle between the rv64 core (master) and the data memory (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_len;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_len, req_signed, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_len, req_signed, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked little-endian 64-bit-word data memory: one request at a time, a fixed number
// of wait states, then a held response carrying extended load data or an error flag.
module dmem_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  len_q, len_d;
    logic        sgn_q, sgn_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [63:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [2:0]    off;
    logic          misal, oor, acc_err;
    logic [63:0]   word, ld_field, ld_data, wsh, st_word;
    logic [7:0]    be_base, be;
    logic          enter_resp, mem_we;

    // Access datapath works on the captured request only; it is consumed on the WAIT->RESP edge.
    always_comb begin
        idx      = addr_q[3 +: AW];
        off      = addr_q[2:0];
        case (len_q)
            2'd0:    misal = 1'b0;
            2'd1:    misal = addr_q[0];
            2'd2:    misal = |addr_q[1:0];
            default: misal = |addr_q[2:0];
        endcase
        oor      = |addr_q[63:AW+3];
        acc_err  = misal | oor;
        word     = mem[idx];
        ld_field = word >> {off, 3'b000};
        case (len_q)
            2'd0:    ld_data = {{56{sgn_q & ld_field[7]}},  ld_field[7:0]};
            2'd1:    ld_data = {{48{sgn_q & ld_field[15]}}, ld_field[15:0]};
            2'd2:    ld_data = {{32{sgn_q & ld_field[31]}}, ld_field[31:0]};
            default: ld_data = ld_field;
        endcase
        case (len_q)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        be  = be_base << off;
        wsh = wdata_q << {off, 3'b000};
        for (int i = 0; i < 8; i++)
            st_word[8*i +: 8] = be[i] ? wsh[8*i +: 8] : word[8*i +: 8];
        enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
        mem_we     = rst && enter_resp && wr_q && !acc_err;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        len_d        = len_q;
        sgn_d        = sgn_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    wr_d        = bus.req_wr;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    len_d       = bus.req_len;
                    sgn_d       = bus.req_signed;
                    cnt_d       = LAT;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // One WAIT pass per counter value down to 0 puts resp_valid LATENCY+1 edges after accept.
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = acc_err;
                    resp_rdata_d = (acc_err || wr_q) ? 64'd0 : ld_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            len_q        <= 2'd0;
            sgn_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            len_q        <= len_d;
            sgn_q        <= sgn_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= st_word;
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 512;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] refm [DEPTH*8];

    function automatic void model(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                                  input logic [1:0] len, input logic sg,
                                  output logic [63:0] rd, output logic er);
        int nb;
        logic [63:0] v;
        nb = 1 << len;
        er = ((a % nb) != 0) || (a >= DEPTH*8);
        rd = 64'd0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) refm[a[11:0] + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = refm[a[11:0] + i];
                if (sg && len != 2'd3 && v[8*nb-1])
                    v = v | ~((64'd1 << (8*nb)) - 64'd1);
                rd = v;
            end
        end
    endfunction

    task automatic scramble();
        bus.req_wr     = 1'($urandom);
        bus.req_addr   = {$urandom, $urandom};
        bus.req_wdata  = {$urandom, $urandom};
        bus.req_len    = 2'($urandom);
        bus.req_signed = 1'($urandom);
    endtask

    // One full transaction; lat = edges from accept to resp_valid, -1 on timeout.
    task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] len, input logic sg,
                       output logic [63:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_len    = len;
        bus.req_signed = sg;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble();
        lat = 0;
        rd  = 64'd0;
        er  = 1'b0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) lat = -1;
        rd = bus.resp_rdata;
        er = bus.resp_err;
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", bus.req_ready); else passed++;
        total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); else passed++;
        total++; if (bus.resp_rdata !== 64'd0) $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); else passed++;
        total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.resp_err); else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_init();
        logic [63:0] rd, erd, wd;
        logic er, eer;
        int lat;
        for (int w = 0; w <= 32; w++) begin
            int widx;
            widx = (w == 32) ? DEPTH - 1 : w;
            wd = {$urandom, $urandom};
            model(1'b1, 64'(widx * 8), wd, 2'd3, 1'b0, erd, eer);
            txn(1'b1, 64'(widx * 8), wd, 2'd3, 1'b0, rd, er, lat);
            total++; if (er !== 1'b0 || rd !== 64'd0) $display("FAIL init_store w=%0d err %b rdata %h want 0/0", widx, er, rd); else passed++;
        end
    endtask

    task automatic test_dword();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        model(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, erd, eer);
        txn(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, rd, er, lat);
        total++; if (lat !== LAT + 1) $display("FAIL dword_store_latency got %0d want %0d", lat, LAT + 1); else passed++;
        total++; if (er !== 1'b0 || rd !== 64'd0) $display("FAIL dword_store_resp err %b rdata %h want 0/0", er, rd); else passed++;
        txn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, rd, er, lat);
        total++; if (lat !== LAT + 1) $display("FAIL dword_load_latency got %0d want %0d", lat, LAT + 1); else passed++;
        total++; if (rd !== 64'h1122334455667788 || er !== 1'b0) $display("FAIL dword_load got %h err %b want 1122334455667788/0", rd, er); else passed++;
    endtask

    task automatic test_byte_merge();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        model(1'b1, 64'h13, 64'hF0, 2'd0, 1'b0, erd, eer);
        txn(1'b1, 64'h13, 64'hF0, 2'd0, 1'b0, rd, er, lat);
        total++; if (er !== 1'b0) $display("FAIL byte_store_err got %b want 0", er); else passed++;
        txn(1'b0, 64'h10, 64'd0, 2'd2, 1'b1, rd, er, lat);
        total++; if (rd !== 64'hFFFFFFFFF0667788 || er !== 1'b0) $display("FAIL word_load_signed got %h want fffffffff0667788", rd); else passed++;
        txn(1'b0, 64'h13, 64'd0, 2'd0, 1'b0, rd, er, lat);
        total++; if (rd !== 64'h00000000000000F0) $display("FAIL byte_load_unsigned got %h want f0", rd); else passed++;
        txn(1'b0, 64'h13, 64'd0, 2'd0, 1'b1, rd, er, lat);
        total++; if (rd !== 64'hFFFFFFFFFFFFFFF0) $display("FAIL byte_load_signed got %h want fffffffffffffff0", rd); else passed++;
    endtask

    task automatic test_misalign();
        logic [63:0] rd;
        logic er;
        int lat;
        txn(1'b0, 64'h12, 64'd0, 2'd2, 1'b0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL misalign_load err %b rdata %h want 1/0", er, rd); else passed++;
        txn(1'b1, 64'h11, 64'hABCD, 2'd1, 1'b0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL misalign_store err %b rdata %h want 1/0", er, rd); else passed++;
        txn(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, rd, er, lat);
        total++; if (rd !== 64'h11223344F0667788 || er !== 1'b0) $display("FAIL misalign_unchanged got %h want 11223344f0667788", rd); else passed++;
    endtask

    task automatic test_range();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        txn(1'b0, 64'h1000, 64'd0, 2'd3, 1'b0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 64'd0) $display("FAIL range_over err %b rdata %h want 1/0", er, rd); else passed++;
        model(1'b0, 64'hFF8, 64'd0, 2'd3, 1'b0, erd, eer);
        txn(1'b0, 64'hFF8, 64'd0, 2'd3, 1'b0, rd, er, lat);
        total++; if (er !== 1'b0 || rd !== erd) $display("FAIL range_last err %b rdata %h want 0/%h", er, rd, erd); else passed++;
    endtask

    task automatic test_backpressure();
        logic [63:0] rd, erd, hold_rd;
        logic er, eer, hold_er;
        int n;
        model(1'b0, 64'h28, 64'd0, 2'd3, 1'b0, erd, eer);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 64'h28;
        bus.req_len = 2'd3; bus.req_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 40) begin @(negedge clk); n++; end
        total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== erd) $display("FAIL bp_first_resp valid %b rdata %h want 1/%h", bus.resp_valid, bus.resp_rdata, erd); else passed++;
        hold_rd = bus.resp_rdata;
        hold_er = bus.resp_err;
        // A store pushed at the busy responder must be ignored.
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 64'h30;
        bus.req_wdata = 64'hBAD0BAD0BAD0BAD0; bus.req_len = 2'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== hold_rd || bus.resp_err !== hold_er || bus.req_ready !== 1'b0)
                $display("FAIL bp_hold c=%0d valid %b rdata %h err %b ready %b want 1/%h/%b/0",
                         c, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, hold_rd, hold_er);
            else passed++;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL bp_release valid %b ready %b want 0/1", bus.resp_valid, bus.req_ready); else passed++;
        total++; if (bus.resp_rdata !== hold_rd) $display("FAIL bp_rdata_held got %h want %h", bus.resp_rdata, hold_rd); else passed++;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        model(1'b0, 64'h30, 64'd0, 2'd3, 1'b0, erd, eer);
        txn(1'b0, 64'h30, 64'd0, 2'd3, 1'b0, rd, er, n);
        total++; if (rd !== erd) $display("FAIL bp_ignored_store got %h want %h", rd, erd); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 64'h20;
        bus.req_wdata = 64'hDEAD; bus.req_len = 2'd3; bus.req_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL rstmid_state valid %b ready %b want 0/1", bus.resp_valid, bus.req_ready); else passed++;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk); #1;
        total++; if (bus.resp_valid !== 1'b0) $display("FAIL rstmid_no_resp valid %b want 0", bus.resp_valid); else passed++;
        model(1'b0, 64'h20, 64'd0, 2'd3, 1'b0, erd, eer);
        txn(1'b0, 64'h20, 64'd0, 2'd3, 1'b0, rd, er, lat);
        total++; if (rd !== erd || rd === 64'hDEAD) $display("FAIL rstmid_mem got %h want %h", rd, erd); else passed++;
    endtask

    task automatic test_random();
        logic [63:0] rd, erd, a, wd;
        logic er, eer, wr, sg;
        logic [1:0] len;
        int lat, pick;
        for (int t = 0; t < 150; t++) begin
            pick = $urandom_range(0, 15);
            if (pick == 0)      a = {$urandom, $urandom};
            else if (pick == 1) a = 64'($urandom_range(32'h1000, 32'h1FFF));
            else if (pick == 2) a = 64'($urandom_range(32'hFF8, 32'hFFF));
            else                a = 64'($urandom_range(0, 32'hFF));
            wr  = 1'($urandom);
            len = 2'($urandom);
            sg  = 1'($urandom);
            wd  = {$urandom, $urandom};
            model(wr, a, wd, len, sg, erd, eer);
            txn(wr, a, wd, len, sg, rd, er, lat);
            total++;
            if (rd !== erd || er !== eer || lat !== LAT + 1)
                $display("FAIL rand t=%0d wr=%b a=%h len=%0d sg=%b got %h/%b lat %0d want %h/%b lat %0d",
                         t, wr, a, len, sg, rd, er, lat, erd, eer, LAT + 1);
            else passed++;
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        scramble();
        test_reset();
        test_init();
        test_dword();
        test_byte_merge();
        test_misalign();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
